// File: rtl/alu_pkg.sv
// Shared types and helpers for the 3-bit sign-magnitude adder/subtractor and its consumers.
package alu_pkg;

  localparam int unsigned RES_W = 4;
  localparam int unsigned MAG_W = 3;

  typedef struct packed {
    logic [RES_W-1:0] r;
    logic             sf;
    logic             zf;
  } alu_result_t;

  // Flags must agree with the result; negative zero is never a legal encoding.
  function automatic logic is_consistent(alu_result_t e);
    logic neg_zero;
    neg_zero = (e.r == {1'b1, {MAG_W{1'b0}}});
    return (e.sf == e.r[RES_W-1]) && (e.zf == (e.r[MAG_W-1:0] == '0)) && !neg_zero;
  endfunction

endpackage

// File: rtl/add_sub_result_fifo_if.sv
// Result handshake bundle: upstream push side and downstream pop side.
interface add_sub_result_fifo_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_r;
  logic             in_sf;
  logic             in_zf;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_r;
  logic             out_sf;
  logic             out_zf;

  modport slave (
    input  in_valid, in_r, in_sf, in_zf, out_ready,
    output in_ready, out_valid, out_r, out_sf, out_zf
  );

  modport master (
    output in_valid, in_r, in_sf, in_zf, out_ready,
    input  in_ready, out_valid, out_r, out_sf, out_zf
  );

endinterface

// File: rtl/alu_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module alu_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/add_sub_result_fifo.sv
// Result buffer behind the adder: in-order FIFO with flag checking and result statistics.
module add_sub_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  add_sub_result_fifo_if.slave   bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   flag_err,
  output logic [CNT_W-1:0]       neg_cnt,
  output logic [CNT_W-1:0]       zero_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  alu_result_t   mem [DEPTH];
  alu_result_t   din;
  alu_result_t   head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] rptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  assign din = '{r: bus.in_r, sf: bus.in_sf, zf: bus.in_zf};

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_r     = head.r;
  assign bus.out_sf    = head.sf;
  assign bus.out_zf    = head.zf;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    rptr_nxt  = rptr;
    count_nxt = count;
    if (pop) begin
      rptr_nxt = rptr + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  // Head is a register loaded with the next-cycle head so that it holds the
  // last shown entry once the buffer empties; a push landing on the new head
  // slot bypasses storage since mem is not yet written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      head     <= '0;
      flag_err <= 1'b0;
    end else begin
      rptr  <= rptr_nxt;
      count <= count_nxt;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (count_nxt != '0) begin
        head <= (push && (wptr == rptr_nxt)) ? din : mem[rptr_nxt];
      end
      if (push && !is_consistent(din)) begin
        flag_err <= 1'b1;
      end
    end
  end

  alu_sat_counter #(.W(CNT_W)) u_neg_cnt (
    .clk (clk),
    .rst (rst),
    .inc (push & bus.in_sf),
    .q   (neg_cnt)
  );

  alu_sat_counter #(.W(CNT_W)) u_zero_cnt (
    .clk (clk),
    .rst (rst),
    .inc (push & bus.in_zf),
    .q   (zero_cnt)
  );

endmodule

// File: tb/tb_add_sub_result_fifo.sv
// Bench for add_sub_result_fifo: directed scenarios then random traffic against a queue model.
module tb_add_sub_result_fifo;
  import alu_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned CNTMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CW-1:0]    count;
  logic             flag_err;
  logic [CNT_W-1:0] neg_cnt;
  logic [CNT_W-1:0] zero_cnt;

  add_sub_result_fifo_if bus ();

  add_sub_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .flag_err (flag_err),
    .neg_cnt  (neg_cnt),
    .zero_cnt (zero_cnt)
  );

  always #5 clk = ~clk;

  alu_result_t mq [$];
  alu_result_t last;
  bit          m_err;
  int unsigned m_neg;
  int unsigned m_zero;
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit entry_ok(logic [3:0] r, bit sf, bit zf);
    bit neg;
    bit zmag;
    neg  = r[3];
    zmag = (r[2:0] == 3'd0);
    if (neg && zmag) return 1'b0;
    return (sf == neg) && (zf == zmag);
  endfunction

  // One clock: drive inputs, advance the model by the same cycle, compare after the edge.
  task automatic step(input bit r_, input bit v, input logic [3:0] d, input bit sf,
                      input bit zf, input bit ordy);
    alu_result_t e;
    bit          acc;
    rst           = r_;
    bus.in_valid  = v;
    bus.in_r      = d;
    bus.in_sf     = sf;
    bus.in_zf     = zf;
    bus.out_ready = ordy;
    if (r_) begin
      mq.delete();
      last   = '0;
      m_err  = 1'b0;
      m_neg  = 0;
      m_zero = 0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (ordy && (mq.size() > 0)) void'(mq.pop_front());
      if (acc) begin
        e.r  = d;
        e.sf = sf;
        e.zf = zf;
        mq.push_back(e);
        if (!entry_ok(d, sf, zf)) m_err = 1'b1;
        if (sf && (m_neg < CNTMAX)) m_neg++;
        if (zf && (m_zero < CNTMAX)) m_zero++;
      end
    end
    if (mq.size() > 0) last = mq[0];
    @(posedge clk);
    #1;
    check("in_ready",  32'(bus.in_ready),  32'(mq.size() != DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    check("out_r",     32'(bus.out_r),     32'(last.r));
    check("out_sf",    32'(bus.out_sf),    32'(last.sf));
    check("out_zf",    32'(bus.out_zf),    32'(last.zf));
    check("count",     32'(count),         32'(mq.size()));
    check("flag_err",  32'(flag_err),      32'(m_err));
    check("neg_cnt",   32'(neg_cnt),       m_neg);
    check("zero_cnt",  32'(zero_cnt),      m_zero);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ordy);
  endtask

  task automatic push_pos(input int unsigned mag, input bit ordy);
    step(1'b0, 1'b1, {1'b0, 3'(mag)}, 1'b0, (mag == 0), ordy);
  endtask

  initial begin
    logic [2:0] mag;
    logic [3:0] d;
    bit         s;
    bit         sf;
    bit         zf;

    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // First entry visible on the cycle after its push.
    push_pos(3, 1'b0);
    idle(1'b1);

    // Fill, then a pop while full does not admit the waiting entry until the next cycle.
    for (int i = 1; i <= 4; i++) push_pos(i, 1'b0);
    push_pos(5, 1'b1);
    push_pos(5, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Steady push+pop at occupancy 2, pointers wrapping.
    push_pos(6, 1'b0);
    push_pos(1, 1'b0);
    for (int i = 0; i < 10; i++) push_pos((i % 6) + 1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Negative zero is stored as-is and latches the error flag.
    step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
    push_pos(2, 1'b1);
    step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Counter saturation.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Reset with three entries held and a push in flight.
    for (int i = 1; i <= 3; i++) push_pos(i, 1'b0);
    push_pos(2, 1'b0);
    step(1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        d  = 4'($urandom);
        sf = 1'($urandom);
        zf = 1'($urandom);
      end else begin
        mag = 3'($urandom_range(0, 6));
        s   = (mag != 0) ? 1'($urandom) : 1'b0;
        d   = {s, mag};
        sf  = s;
        zf  = (mag == 0);
      end
      step(($urandom_range(0, 63) == 0), 1'($urandom), d, sf, zf, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
